mac_array_sequencer: RTL and testbench
======================================

Name: mac_array_sequencer

Overview:
Instruction-driven controller that sequences the MAC array control datapath.
- For a compute instruction: reads one kernel's weights out of the weight BRAM, shifts them into the per-MAC preload registers, and commits them to the MAC array.
- Then streams ifmaps from the ifmap FIFO for a programmed beat count, drains the pipeline, and reports completion on a 32-bit status word (the axi_control_3 source).
- Sits between the AXI control registers and the MAC array control block.

Parameters:
BRAM_ADDRESS_WIDTH, 12, weight BRAM address width
CNT_WIDTH, 16, width of ifmap beat counter
DRAIN_CYCLES, 4, cycles waited after last ifmap beat before done (MAC pipeline depth); legal range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst  in  32  instruction word; 32'd87 = INST_COMPUTE, 32'd88 = INST_LOADIFMAPS
inst_valid  in  1  instruction strobe; accepted only when inst_ready=1
inst_ready  out  1  high in IDLE
kernel_size  in  5  kernel size K, legal 1..5; sampled on accept
weight_base_addr  in  BRAM_ADDRESS_WIDTH  first weight row address; sampled on accept
ifmap_count  in  CNT_WIDTH  ifmap beats to stream; sampled on accept
bram_addr  out  BRAM_ADDRESS_WIDTH  weight BRAM read address
bram_rd_en  out  1  BRAM read enable (read latency exactly 1 cycle)
load_weight_preload  out  1  shift one 5-bit weight row into preload registers
load_MAC_weight  out  1  one-cycle commit of preload to MAC array
load_ifmaps  out  1  pop/consume one ifmap beat
ifmaps_fifo_empty  in  1  ifmap FIFO empty
done  out  1  one-cycle pulse at instruction completion
status  out  32  [0] busy, [1] done_sticky, [2] err_sticky, [7:3] K latched, [31:8] 0 (see optional feature)

Behaviour:
- Reset: all outputs 0 except inst_ready=1. State IDLE. Counters 0. Sticky bits 0.
- Reset mid-operation aborts immediately; no further strobes are issued.
- States: IDLE, WREAD, WSHIFT, WCOMMIT, STREAM, DRAIN, DONE.
- IDLE, inst_valid=1 with a legal accept:
  - Latch K, base address, and count; clear done_sticky and err_sticky.
  - inst=87 -> WREAD; inst=88 -> STREAM.
- IDLE, illegal accept (unknown opcode, or K=0, or K>5 on opcode 87):
  - Set err_sticky and stay in IDLE; nothing else is latched.
  - K is ignored for opcode 88.
- WREAD:
  - Cycle-by-cycle, bram_rd_en=1 with bram_addr = base+i for i=0..K-1 (K consecutive cycles).
  - load_weight_preload is bram_rd_en delayed by exactly 1 cycle, so K preload pulses land on cycles 2..K+1 after accept.
  - After the last read -> WSHIFT (1 cycle, final preload pulse) -> WCOMMIT.
- WCOMMIT: load_MAC_weight=1 for exactly one cycle -> STREAM.
- STREAM:
  - load_ifmaps = ~ifmaps_fifo_empty & (beats_left != 0).
  - Decrement beats_left on each asserted beat.
  - Empty FIFO stalls with no strobe; there is no timeout.
  - When beats_left reaches 0 -> DRAIN.
  - ifmap_count=0 -> DRAIN immediately, with no load_ifmaps.
- DRAIN: wait DRAIN_CYCLES cycles -> DONE.
- DONE: done=1 for one cycle, done_sticky=1 -> IDLE.
- Address arithmetic: base+i wraps modulo 2^BRAM_ADDRESS_WIDTH.
- inst_valid outside IDLE is ignored (inst_ready=0); no error is raised.
- load_weight_preload, load_MAC_weight and load_ifmaps are mutually exclusive in every cycle.
- status[0] = (state != IDLE).

Optional Feature:
MAC_SEQ_PERF_EN
- With the macro: a 16-bit saturating stall counter counts STREAM cycles with ifmaps_fifo_empty=1 and beats_left!=0.
  - It is cleared on instruction accept and visible on status[31:16].
- Without the macro: status[31:16]=0 and the counter logic is absent.

Decomposition:
- Shared package holds: opcode constants INST_COMPUTE=87 and INST_LOADIFMAPS=88, the state encoding localparams, status bit index constants, and K_MAX=5.
- One sub-module, mac_seq_weight_reader: the WREAD address counter plus the 1-cycle-delayed preload strobe generator.
- All other logic is a single FSM.

Test Plan:
- Opcode 87, K=3, base=0x010, count=4, FIFO never empty -> bram_addr 0x010/0x011/0x012; 3 preload pulses, each 1 cycle after its read; 1 load_MAC_weight; 4 consecutive load_ifmaps; done exactly 4 cycles after last beat; status=0x1A.
- Opcode 88, count=3, FIFO empty for 5 cycles mid-stream -> no bram_rd_en or preload; exactly 3 load_ifmaps, none while empty. With MAC_SEQ_PERF_EN, status[31:16]=5.
- Opcode 87 with K=0, then with K=6, then opcode 0x55 -> err_sticky=1, inst_ready stays 1, no strobes. A following legal instruction clears err.
- Opcode 87, K=5, base=0xFFE -> addresses 0xFFE, 0xFFF, 0x000, 0x001, 0x002.
- Opcode 88 with count=0 -> no load_ifmaps; done after DRAIN_CYCLES+2 cycles.
- rst_n asserted during STREAM with 2 beats left -> all strobes 0 asynchronously; after release, IDLE, status=0, inst_ready=1.

Source files
------------

// File: rtl/mac_array_sequencer_pkg.sv
// Shared opcodes, state encoding and status layout for the MAC array sequencer.
package mac_array_sequencer_pkg;

   localparam logic [31:0] INST_COMPUTE    = 32'd87;
   localparam logic [31:0] INST_LOADIFMAPS = 32'd88;

   localparam logic [4:0] K_MAX = 5'd5;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WREAD   = 3'd1;
   localparam logic [2:0] ST_WSHIFT  = 3'd2;
   localparam logic [2:0] ST_WCOMMIT = 3'd3;
   localparam logic [2:0] ST_STREAM  = 3'd4;
   localparam logic [2:0] ST_DRAIN   = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_WREAD   = ST_WREAD,
      S_WSHIFT  = ST_WSHIFT,
      S_WCOMMIT = ST_WCOMMIT,
      S_STREAM  = ST_STREAM,
      S_DRAIN   = ST_DRAIN,
      S_DONE    = ST_DONE
   } seq_state_t;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_ERR      = 2;
   localparam int STAT_K_LSB    = 3;
   localparam int STAT_K_MSB    = 7;
   localparam int STAT_PERF_LSB = 16;

endpackage

// File: rtl/mac_seq_weight_reader.sv
// Weight BRAM read address counter and the one-cycle-delayed preload strobe.
module mac_seq_weight_reader #(
   parameter int BRAM_ADDRESS_WIDTH = 12
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          active,
   input  logic [BRAM_ADDRESS_WIDTH-1:0] base,
   input  logic [4:0]                    k,
   output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
   output logic                          bram_rd_en,
   output logic                          preload,
   output logic                          last
);

   logic [2:0] idx_q, idx_d;
   logic       preload_q, preload_d;

   always_comb begin
      idx_d      = active ? idx_q + 3'd1 : 3'd0;
      preload_d  = active;
      bram_rd_en = active;
      // Address wraps naturally at the BRAM width.
      bram_addr  = active ? base + BRAM_ADDRESS_WIDTH'(idx_q) : '0;
      last       = active && ({2'b00, idx_q} == (k - 5'd1));
      preload    = preload_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= 3'd0;
         preload_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         preload_q <= preload_d;
      end
   end

endmodule

// File: rtl/mac_array_sequencer.sv
// Instruction-driven MAC array control sequencer (weight load, ifmap stream, drain).
// Optional stall counter on status[31:16] built with `define MAC_SEQ_PERF_EN.
module mac_array_sequencer
   import mac_array_sequencer_pkg::*;
#(
   parameter int BRAM_ADDRESS_WIDTH = 12,
   parameter int CNT_WIDTH          = 16,
   parameter int DRAIN_CYCLES       = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [31:0]                   inst,
   input  logic                          inst_valid,
   output logic                          inst_ready,
   input  logic [4:0]                    kernel_size,
   input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
   input  logic [CNT_WIDTH-1:0]          ifmap_count,
   output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
   output logic                          bram_rd_en,
   output logic                          load_weight_preload,
   output logic                          load_MAC_weight,
   output logic                          load_ifmaps,
   input  logic                          ifmaps_fifo_empty,
   output logic                          done,
   output logic [31:0]                   status
);

   seq_state_t                    state_q, state_d;
   logic [4:0]                    k_q, k_d;
   logic [BRAM_ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [CNT_WIDTH-1:0]          beats_q, beats_d;
   logic [3:0]                    drain_q, drain_d;
   logic                          done_sticky_q, done_sticky_d;
   logic                          err_q, err_d;
   logic                          op_legal;
   logic                          rd_last;
   logic [15:0]                   perf_w;

   // Opcode 88 ignores K entirely; only compute checks its range.
   assign op_legal = ((inst == INST_COMPUTE) && (kernel_size != 5'd0) && (kernel_size <= K_MAX))
                   || (inst == INST_LOADIFMAPS);
   assign inst_ready = (state_q == S_IDLE);

   mac_seq_weight_reader #(
      .BRAM_ADDRESS_WIDTH(BRAM_ADDRESS_WIDTH)
   ) u_weight_reader (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (state_q == S_WREAD),
      .base       (base_q),
      .k          (k_q),
      .bram_addr  (bram_addr),
      .bram_rd_en (bram_rd_en),
      .preload    (load_weight_preload),
      .last       (rd_last)
   );

   always_comb begin
      state_d         = state_q;
      k_d             = k_q;
      base_d          = base_q;
      beats_d         = beats_q;
      drain_d         = drain_q;
      done_sticky_d   = done_sticky_q;
      err_d           = err_q;
      load_MAC_weight = 1'b0;
      load_ifmaps     = 1'b0;
      done            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (inst_valid) begin
               if (op_legal) begin
                  k_d           = kernel_size;
                  base_d        = weight_base_addr;
                  beats_d       = ifmap_count;
                  done_sticky_d = 1'b0;
                  err_d         = 1'b0;
                  state_d       = (inst == INST_COMPUTE) ? S_WREAD : S_STREAM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WREAD: begin
            if (rd_last) state_d = S_WSHIFT;
         end
         S_WSHIFT: state_d = S_WCOMMIT;
         S_WCOMMIT: begin
            load_MAC_weight = 1'b1;
            state_d         = S_STREAM;
         end
         S_STREAM: begin
            drain_d = 4'd0;
            if (beats_q == '0) begin
               state_d = S_DRAIN;
            end else if (!ifmaps_fifo_empty) begin
               load_ifmaps = 1'b1;
               beats_d     = beats_q - CNT_WIDTH'(1);
               if (beats_q == CNT_WIDTH'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_q == 4'(DRAIN_CYCLES - 1)) state_d = S_DONE;
            else drain_d = drain_q + 4'd1;
         end
         S_DONE: begin
            done          = 1'b1;
            done_sticky_d = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         k_q           <= 5'd0;
         base_q        <= '0;
         beats_q       <= '0;
         drain_q       <= 4'd0;
         done_sticky_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         base_q        <= base_d;
         beats_q       <= beats_d;
         drain_q       <= drain_d;
         done_sticky_q <= done_sticky_d;
         err_q         <= err_d;
      end
   end

`ifdef MAC_SEQ_PERF_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && inst_valid && op_legal) begin
         stall_d = 16'd0;
      end else if ((state_q == S_STREAM) && ifmaps_fifo_empty && (beats_q != '0)
                   && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= 16'd0;
      else        stall_q <= stall_d;
   end

   assign perf_w = stall_q;
`else
   assign perf_w = 16'd0;
`endif

   always_comb begin
      status                          = 32'd0;
      status[STAT_BUSY]               = (state_q != S_IDLE);
      status[STAT_DONE]               = done_sticky_q;
      status[STAT_ERR]                = err_q;
      status[STAT_K_MSB:STAT_K_LSB]   = k_q;
      status[31:STAT_PERF_LSB]        = perf_w;
   end

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed self-checking bench for mac_array_sequencer.
module tb_mac_array_sequencer;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [4:0]  kernel_size;
   logic [11:0] weight_base_addr;
   logic [15:0] ifmap_count;
   logic [11:0] bram_addr;
   logic        bram_rd_en;
   logic        load_weight_preload;
   logic        load_MAC_weight;
   logic        load_ifmaps;
   logic        ifmaps_fifo_empty;
   logic        done;
   logic [31:0] status;

   mac_array_sequencer #(
      .BRAM_ADDRESS_WIDTH(12),
      .CNT_WIDTH(16),
      .DRAIN_CYCLES(4)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .inst                (inst),
      .inst_valid          (inst_valid),
      .inst_ready          (inst_ready),
      .kernel_size         (kernel_size),
      .weight_base_addr    (weight_base_addr),
      .ifmap_count         (ifmap_count),
      .bram_addr           (bram_addr),
      .bram_rd_en          (bram_rd_en),
      .load_weight_preload (load_weight_preload),
      .load_MAC_weight     (load_MAC_weight),
      .load_ifmaps         (load_ifmaps),
      .ifmaps_fifo_empty   (ifmaps_fifo_empty),
      .done                (done),
      .status              (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor sampled on the falling edge.
   int n_rd = 0, n_pre = 0, n_mac = 0, n_if = 0, n_done = 0;
   int n_excl = 0, n_lag = 0, n_ife = 0;
   int rd_addr [0:63];
   int rd_cyc  [0:63];
   int pre_cyc [0:63];
   int if_cyc  [0:63];
   int mac_cyc = 0, done_cyc = 0;
   logic prev_rd = 1'b0;

   always @(negedge clk) begin
      if (bram_rd_en) begin
         rd_addr[n_rd[5:0]] <= int'(bram_addr);
         rd_cyc[n_rd[5:0]]  <= cyc;
         n_rd               <= n_rd + 1;
      end
      if (load_weight_preload) begin
         pre_cyc[n_pre[5:0]] <= cyc;
         n_pre               <= n_pre + 1;
         if (!prev_rd) n_lag <= n_lag + 1;
      end
      if (load_MAC_weight) begin
         mac_cyc <= cyc;
         n_mac   <= n_mac + 1;
      end
      if (load_ifmaps) begin
         if_cyc[n_if[5:0]] <= cyc;
         n_if              <= n_if + 1;
         if (ifmaps_fifo_empty) n_ife <= n_ife + 1;
      end
      if (done) begin
         done_cyc <= cyc;
         n_done   <= n_done + 1;
      end
      if ((int'(load_weight_preload) + int'(load_MAC_weight) + int'(load_ifmaps)) > 1)
         n_excl <= n_excl + 1;
      prev_rd <= bram_rd_en;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int acc = 0;
   int s_rd = 0, s_pre = 0, s_mac = 0, s_if = 0, s_done = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] op, input logic [4:0] k,
                        input logic [11:0] b, input logic [15:0] c);
      inst             = op;
      kernel_size      = k;
      weight_base_addr = b;
      ifmap_count      = c;
      inst_valid       = 1'b1;
      s_rd   = n_rd;
      s_pre  = n_pre;
      s_mac  = n_mac;
      s_if   = n_if;
      s_done = n_done;
      @(posedge clk);
      #1;
      acc        = cyc - 1;
      inst_valid = 1'b0;
      inst       = 32'd0;
   endtask

   task automatic wait_done(input string tag);
      int guard;
      guard = 0;
      while ((n_done == s_done) && (guard < 200)) begin
         tick();
         guard++;
      end
      if (n_done == s_done) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      rst_n             = 1'b0;
      inst              = 32'd0;
      inst_valid        = 1'b0;
      kernel_size       = 5'd0;
      weight_base_addr  = 12'd0;
      ifmap_count       = 16'd0;
      ifmaps_fifo_empty = 1'b0;
      #1;
      check("rst_ready",  32'(inst_ready), 32'd1);
      check("rst_status", status, 32'd0);
      check("rst_strobes", {27'd0, bram_rd_en, load_weight_preload, load_MAC_weight,
                            load_ifmaps, done}, 32'd0);
      check("rst_addr", 32'(bram_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Compute K=3, base 0x010, 4 beats, FIFO never empty.
      issue(32'd87, 5'd3, 12'h010, 16'd4);
      check("t1_busy",  status & 32'h1, 32'd1);
      check("t1_ready", 32'(inst_ready), 32'd0);
      inst = 32'h55; inst_valid = 1'b1;
      repeat (3) tick();
      inst_valid = 1'b0; inst = 32'd0;
      wait_done("t1");
      check("t1_nrd", 32'(n_rd - s_rd), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("t1_addr",    32'(rd_addr[s_rd + i]), 32'h010 + 32'(i));
         check("t1_rd_cyc",  32'(rd_cyc[s_rd + i] - acc), 32'(i + 1));
         check("t1_pre_cyc", 32'(pre_cyc[s_pre + i] - acc), 32'(i + 2));
      end
      check("t1_npre",    32'(n_pre - s_pre), 32'd3);
      check("t1_nmac",    32'(n_mac - s_mac), 32'd1);
      check("t1_mac_cyc", 32'(mac_cyc - acc), 32'd5);
      check("t1_nif",     32'(n_if - s_if), 32'd4);
      for (int i = 0; i < 4; i++)
         check("t1_if_cyc", 32'(if_cyc[s_if + i] - acc), 32'(i + 6));
      check("t1_done_cyc", 32'(done_cyc - acc), 32'd14);
      check("t1_ndone",    32'(n_done - s_done), 32'd1);
      check("t1_status",   status, 32'h0000_001A);
      check("t1_ready_end", 32'(inst_ready), 32'd1);

      // Load-ifmaps, 3 beats, FIFO empty for 5 cycles after the first beat.
      issue(32'd88, 5'd0, 12'h000, 16'd3);
      tick();
      ifmaps_fifo_empty = 1'b1;
      repeat (5) tick();
      ifmaps_fifo_empty = 1'b0;
      wait_done("t2");
      check("t2_nrd",  32'(n_rd - s_rd), 32'd0);
      check("t2_npre", 32'(n_pre - s_pre), 32'd0);
      check("t2_nmac", 32'(n_mac - s_mac), 32'd0);
      check("t2_nif",  32'(n_if - s_if), 32'd3);
      check("t2_if0",  32'(if_cyc[s_if]     - acc), 32'd1);
      check("t2_if1",  32'(if_cyc[s_if + 1] - acc), 32'd7);
      check("t2_if2",  32'(if_cyc[s_if + 2] - acc), 32'd8);
      check("t2_done_cyc", 32'(done_cyc - acc), 32'd13);
      check("t2_status_lo", status & 32'h0000_FFFF, 32'h0000_0002);
`ifdef MAC_SEQ_PERF_EN
      check("t2_stall", status >> 16, 32'd5);
`else
      check("t2_stall", status >> 16, 32'd0);
`endif

      // Illegal accepts: K=0, K=6, unknown opcode.
      s_rd = n_rd; s_pre = n_pre; s_mac = n_mac; s_if = n_if; s_done = n_done;
      inst = 32'd87; kernel_size = 5'd0; inst_valid = 1'b1;
      tick();
      check("t3_err_k0",   status & 32'h4, 32'h4);
      check("t3_ready_k0", 32'(inst_ready), 32'd1);
      inst = 32'd87; kernel_size = 5'd6;
      tick();
      check("t3_ready_k6", 32'(inst_ready), 32'd1);
      inst = 32'h55; kernel_size = 5'd3;
      tick();
      inst_valid = 1'b0; inst = 32'd0;
      repeat (3) tick();
      check("t3_status", status, 32'h0000_0006);
      check("t3_ready",  32'(inst_ready), 32'd1);
      check("t3_strobes", 32'((n_rd - s_rd) + (n_pre - s_pre) + (n_mac - s_mac)
                              + (n_if - s_if) + (n_done - s_done)), 32'd0);

      // Compute K=5 at base 0xFFE: address wrap, and err cleared by a legal accept.
      issue(32'd87, 5'd5, 12'hFFE, 16'd1);
      check("t4_status_busy", status, 32'h0000_0029);
      wait_done("t4");
      check("t4_nrd", 32'(n_rd - s_rd), 32'd5);
      check("t4_a0", 32'(rd_addr[s_rd]),     32'hFFE);
      check("t4_a1", 32'(rd_addr[s_rd + 1]), 32'hFFF);
      check("t4_a2", 32'(rd_addr[s_rd + 2]), 32'h000);
      check("t4_a3", 32'(rd_addr[s_rd + 3]), 32'h001);
      check("t4_a4", 32'(rd_addr[s_rd + 4]), 32'h002);
      check("t4_pre_last", 32'(pre_cyc[s_pre + 4] - acc), 32'd6);
      check("t4_done_cyc", 32'(done_cyc - acc), 32'd13);
      check("t4_status",   status, 32'h0000_002A);

      // Load-ifmaps with zero beats.
      issue(32'd88, 5'd2, 12'h000, 16'd0);
      wait_done("t5");
      check("t5_nif", 32'(n_if - s_if), 32'd0);
      check("t5_done_cyc", 32'(done_cyc - acc), 32'd6);

      // Reset while streaming with 2 beats outstanding.
      ifmaps_fifo_empty = 1'b1;
      issue(32'd88, 5'd1, 12'h000, 16'd2);
      tick();
      ifmaps_fifo_empty = 1'b0;
      #1;
      check("t6_pre_rst_beat", 32'(load_ifmaps), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_strobes", {27'd0, bram_rd_en, load_weight_preload, load_MAC_weight,
                               load_ifmaps, done}, 32'd0);
      check("t6_rst_status", status, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      check("t6_status", status, 32'd0);
      check("t6_ready",  32'(inst_ready), 32'd1);
      check("t6_nif",    32'(n_if - s_if), 32'd0);
      check("t6_ndone",  32'(n_done - s_done), 32'd0);

      check("excl",        32'(n_excl), 32'd0);
      check("preload_lag", 32'(n_lag), 32'd0);
      check("if_on_empty", 32'(n_ife), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
